// File: rtl/texel_filter_pipe.sv
`timescale 1ns/1ps
// texel_filter_pipe: three-stage texture filter (nearest / bilinear / trilinear).
//   S1: horizontal lerps  S2: vertical lerp  S3: mip lerp + output register.
// Optional feature macro: TEXFILT_TRILINEAR_EN adds the level-B quad, flod and
// a second bilinear datapath. Without it mode=2 behaves as bilinear.
// Handshake: a port transfers when valid && ready are high on a rising clk edge.
// The whole pipe advances together when adv = !out_valid || out_ready; in_ready
// is adv, so a stalled output freezes every stage and nothing is lost or repeated.
module texel_filter_pipe #(
  parameter int CHANNELS   = 4,
  parameter int CH_W       = 8,
  parameter int FRACT_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               mode,
  input  logic [CHANNELS*CH_W-1:0] t00,
  input  logic [CHANNELS*CH_W-1:0] t10,
  input  logic [CHANNELS*CH_W-1:0] t01,
  input  logic [CHANNELS*CH_W-1:0] t11,
`ifdef TEXFILT_TRILINEAR_EN
  input  logic [CHANNELS*CH_W-1:0] u00,
  input  logic [CHANNELS*CH_W-1:0] u10,
  input  logic [CHANNELS*CH_W-1:0] u01,
  input  logic [CHANNELS*CH_W-1:0] u11,
  input  logic [FRACT_BITS-1:0]    flod,
`endif
  input  logic [FRACT_BITS-1:0]    fx,
  input  logic [FRACT_BITS-1:0]    fy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CHANNELS*CH_W-1:0] out_pixel
);

  localparam int PIX_W = CHANNELS * CH_W;
  localparam int F     = FRACT_BITS;
  localparam int PW    = CH_W + F + 1;

  // Rounded lerp on one channel: (a*(2^F-f) + b*f + 2^(F-1)) >> F.
  function automatic logic [CH_W-1:0] lerp_ch(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b,
                                               input logic [F-1:0]    f);
    logic [PW-1:0] wa;
    logic [PW-1:0] p;
    wa = (PW'(1) << F) - PW'(f);
    p  = PW'(a) * wa + PW'(b) * PW'(f) + (PW'(1) << (F - 1));
    return p[F +: CH_W];
  endfunction

  // Channel-wise lerp over a packed pixel.
  function automatic logic [PIX_W-1:0] lerp_px(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b,
                                               input logic [F-1:0]     f);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      r[c*CH_W +: CH_W] = lerp_ch(a[c*CH_W +: CH_W], b[c*CH_W +: CH_W], f);
    end
    return r;
  endfunction

  logic adv;

  // Mode is folded into the weights at capture: nearest zeroes every weight
  // (a lerp with f=0 returns a exactly, so t00 passes through untouched) and
  // any mode other than trilinear zeroes the mip weight.
  logic [F-1:0] fx_w, fy_w;

  logic             s1_valid_q, s1_valid_d;
  logic [PIX_W-1:0] s1_ha0_q, s1_ha0_d, s1_ha1_q, s1_ha1_d;
  logic [F-1:0]     s1_fy_q, s1_fy_d;
  logic             s2_valid_q, s2_valid_d;
  logic [PIX_W-1:0] s2_va_q, s2_va_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
`ifdef TEXFILT_TRILINEAR_EN
  logic [F-1:0]     flod_w;
  logic [PIX_W-1:0] s1_hb0_q, s1_hb0_d, s1_hb1_q, s1_hb1_d;
  logic [F-1:0]     s1_flod_q, s1_flod_d, s2_flod_q, s2_flod_d;
  logic [PIX_W-1:0] s2_vb_q, s2_vb_d;
`endif

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;

  // Next-state for all three stages; loads only take effect when adv is high.
  always_comb begin
    fx_w        = (mode == 2'd0) ? '0 : fx;
    fy_w        = (mode == 2'd0) ? '0 : fy;
    s1_valid_d  = in_valid;
    s1_ha0_d    = lerp_px(t00, t10, fx_w);
    s1_ha1_d    = lerp_px(t01, t11, fx_w);
    s1_fy_d     = fy_w;
    s2_valid_d  = s1_valid_q;
    s2_va_d     = lerp_px(s1_ha0_q, s1_ha1_q, s1_fy_q);
    out_valid_d = s2_valid_q;
`ifdef TEXFILT_TRILINEAR_EN
    flod_w      = (mode == 2'd2) ? flod : '0;
    s1_hb0_d    = lerp_px(u00, u10, fx_w);
    s1_hb1_d    = lerp_px(u01, u11, fx_w);
    s1_flod_d   = flod_w;
    s2_vb_d     = lerp_px(s1_hb0_q, s1_hb1_q, s1_fy_q);
    s2_flod_d   = s1_flod_q;
    out_pixel_d = s2_valid_q ? lerp_px(s2_va_q, s2_vb_q, s2_flod_q) : out_pixel_q;
`else
    out_pixel_d = s2_valid_q ? s2_va_q : out_pixel_q;
`endif
  end

  // Pipeline registers: cleared valids on reset, whole pipe frozen while !adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else if (adv) begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  // Datapath registers carry no reset; their stage valid qualifies them.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_ha0_q  <= s1_ha0_d;
      s1_ha1_q  <= s1_ha1_d;
      s1_fy_q   <= s1_fy_d;
      s2_va_q   <= s2_va_d;
`ifdef TEXFILT_TRILINEAR_EN
      s1_hb0_q  <= s1_hb0_d;
      s1_hb1_q  <= s1_hb1_d;
      s1_flod_q <= s1_flod_d;
      s2_vb_q   <= s2_vb_d;
      s2_flod_q <= s2_flod_d;
`endif
    end
  end

endmodule

// File: tb/tb_texel_filter_pipe.sv
`timescale 1ns/1ps
// Directed bench for texel_filter_pipe (CHANNELS=4, CH_W=8, FRACT_BITS=8).
module tb_texel_filter_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] t00, t10, t01, t11;
  logic [31:0] u00, u10, u01, u11;
  logic [7:0]  fx, fy, flod;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pixel;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  texel_filter_pipe #(.CHANNELS(4), .CH_W(8), .FRACT_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .t00(t00), .t10(t10), .t01(t01), .t11(t11),
`ifdef TEXFILT_TRILINEAR_EN
    .u00(u00), .u10(u10), .u01(u01), .u11(u11), .flod(flod),
`endif
    .fx(fx), .fy(fy),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference lerp straight from the formula, on plain integers.
  function automatic int lm(input int a, input int b, input int f);
    return (a * (256 - f) + b * f + 128) >> 8;
  endfunction

  function automatic logic [31:0] model(input logic [1:0] m,
      input logic [31:0] a00, input logic [31:0] a10, input logic [31:0] a01, input logic [31:0] a11,
      input logic [31:0] b00, input logic [31:0] b10, input logic [31:0] b01, input logic [31:0] b11,
      input int wx, input int wy, input int wl);
    logic [31:0] r;
    int va, vb, h0, h1;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      if (m == 2'd0) begin
        r[c*8 +: 8] = a00[c*8 +: 8];
      end else begin
        h0 = lm(int'(a00[c*8 +: 8]), int'(a10[c*8 +: 8]), wx);
        h1 = lm(int'(a01[c*8 +: 8]), int'(a11[c*8 +: 8]), wx);
        va = lm(h0, h1, wy);
        h0 = lm(int'(b00[c*8 +: 8]), int'(b10[c*8 +: 8]), wx);
        h1 = lm(int'(b01[c*8 +: 8]), int'(b11[c*8 +: 8]), wx);
        vb = lm(h0, h1, wy);
`ifdef TEXFILT_TRILINEAR_EN
        if (m == 2'd2) va = lm(va, vb, wl);
`endif
        r[c*8 +: 8] = va[7:0];
      end
    end
    return r;
  endfunction

  // Driver: one transfer with out_ready=1, then observe the three following cycles.
  task automatic send_one(input logic [1:0] m,
      input logic [31:0] a00, input logic [31:0] a10, input logic [31:0] a01, input logic [31:0] a11,
      input logic [31:0] b00, input logic [31:0] b10, input logic [31:0] b01, input logic [31:0] b11,
      input logic [7:0] wx, input logic [7:0] wy, input logic [7:0] wl,
      output logic ov1, output logic ov2, output logic ov3, output logic [31:0] pix);
    mode = m; t00 = a00; t10 = a10; t01 = a01; t11 = a11;
    u00 = b00; u10 = b10; u01 = b01; u11 = b11;
    fx = wx; fy = wy; flod = wl;
    in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    mode = 2'd1; fx = 8'h5A; fy = 8'hA5; t00 = 32'hDEADBEEF;
    ov1 = out_valid;
    tick;
    ov2 = out_valid;
    tick;
    ov3 = out_valid;
    pix = out_pixel;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (out_pixel !== 32'h0) begin n_fail++; $display("FAIL reset_out_pixel got=%h want=00000000", out_pixel); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_bilinear_centre;
    logic ov1, ov2, ov3; logic [31:0] pix;
    send_one(2'd1, 32'h0, 32'hFF, 32'h0, 32'hFF, 32'h0, 32'h0, 32'h0, 32'h0,
             8'd128, 8'd0, 8'd0, ov1, ov2, ov3, pix);
    n_checks++;
    if (ov1 !== 1'b0 || ov2 !== 1'b0 || ov3 !== 1'b1) begin
      n_fail++; $display("FAIL centre_latency got=%b%b%b want=001", ov1, ov2, ov3);
    end
    n_checks++;
    if (pix !== 32'h00000080) begin n_fail++; $display("FAIL centre_value got=%h want=00000080", pix); end
  endtask

  task automatic test_weight_edges;
    logic ov1, ov2, ov3; logic [31:0] pix;
    send_one(2'd1, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'hFFEEDDCC, 32'h0, 32'h0, 32'h0, 32'h0,
             8'd0, 8'd0, 8'd0, ov1, ov2, ov3, pix);
    n_checks++;
    if (pix !== 32'h12345678) begin n_fail++; $display("FAIL zero_weights got=%h want=12345678", pix); end
    send_one(2'd1, 32'hC8C8C8C8, 32'hC8C8C8C8, 32'hC8C8C8C8, 32'hC8C8C8C8, 32'h0, 32'h0, 32'h0, 32'h0,
             8'd77, 8'd180, 8'd0, ov1, ov2, ov3, pix);
    n_checks++;
    if (pix !== 32'hC8C8C8C8) begin n_fail++; $display("FAIL flat_200 got=%h want=c8c8c8c8", pix); end
    send_one(2'd1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0,
             8'd255, 8'd0, 8'd0, ov1, ov2, ov3, pix);
    n_checks++;
    if (pix !== 32'hFEFEFEFE) begin n_fail++; $display("FAIL fx_255 got=%h want=fefefefe", pix); end
  endtask

  task automatic test_nearest;
    logic ov1, ov2, ov3; logic [31:0] pix;
    send_one(2'd0, 32'h11223344, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
             32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
             8'd200, 8'd200, 8'd200, ov1, ov2, ov3, pix);
    n_checks++;
    if (ov1 !== 1'b0 || ov2 !== 1'b0 || ov3 !== 1'b1) begin
      n_fail++; $display("FAIL nearest_latency got=%b%b%b want=001", ov1, ov2, ov3);
    end
    n_checks++;
    if (pix !== 32'h11223344) begin n_fail++; $display("FAIL nearest_value got=%h want=11223344", pix); end
  endtask

  task automatic test_trilinear;
    logic ov1, ov2, ov3; logic [31:0] pix;
    logic [31:0] want;
`ifdef TEXFILT_TRILINEAR_EN
    want = 32'h32323232;
`else
    want = 32'h00000000;
`endif
    send_one(2'd2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h64646464, 32'h64646464, 32'h64646464, 32'h64646464,
             8'd90, 8'd30, 8'd128, ov1, ov2, ov3, pix);
    n_checks++;
    if (ov3 !== 1'b1 || pix !== want) begin
      n_fail++; $display("FAIL trilinear got=%b/%h want=1/%h", ov3, pix, want);
    end
  endtask

  // Three nearest-mode pixels on consecutive cycles must leave on consecutive cycles.
  task automatic test_back_to_back;
    logic [31:0] want;
    out_ready = 1'b1; mode = 2'd0; fx = 8'd0; fy = 8'd0; flod = 8'd0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 3);
      t00 = 32'h01010101 * (i + 1);
      tick;
      want = 32'h01010101 * (i - 1);
      n_checks++;
      if (out_valid !== (i >= 2 && i <= 4)) begin
        n_fail++; $display("FAIL b2b_valid cycle=%0d got=%b", i + 1, out_valid);
      end
      if (i >= 2 && i <= 4) begin
        n_checks++;
        if (out_pixel !== want) begin n_fail++; $display("FAIL b2b_value cycle=%0d got=%h want=%h", i + 1, out_pixel, want); end
      end
    end
  endtask

  task automatic test_mid_reset;
    mode = 2'd1; t00 = 32'h55555555; t10 = 32'h55555555; t01 = 32'h55555555; t11 = 32'h55555555;
    in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
    tick;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_drain got=%b want=0", out_valid); end
  endtask

  // 20 random pixels, in_valid held high, out_ready from an LFSR; scoreboard on exp_q.
  task automatic test_backpressure;
    logic [7:0] lfsr;
    int sent, got, cycles;
    logic xin, xout;
    logic [31:0] want;
    lfsr = 8'hA5; sent = 0; got = 0; cycles = 0;
    mode = 2'($urandom_range(0, 3));
    t00 = $urandom; t10 = $urandom; t01 = $urandom; t11 = $urandom;
    u00 = $urandom; u10 = $urandom; u01 = $urandom; u11 = $urandom;
    fx = 8'($urandom_range(0, 255)); fy = 8'($urandom_range(0, 255)); flod = 8'($urandom_range(0, 255));
    while ((sent < 20 || exp_q.size() > 0) && cycles < 600) begin
      in_valid  = (sent < 20);
      out_ready = lfsr[0];
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      #1;
      xin  = in_valid && in_ready;
      xout = out_valid && out_ready;
      if (out_ready && !in_ready) begin
        n_checks++; n_fail++; $display("FAIL stream_rate cycle=%0d in_ready=0 with out_ready=1", cycles);
      end
      if (xout) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra got=%h want=none", out_pixel);
        end else begin
          want = exp_q.pop_front();
          got++;
          if (out_pixel !== want) begin n_fail++; $display("FAIL stream_value idx=%0d got=%h want=%h", got - 1, out_pixel, want); end
        end
      end
      if (xin) exp_q.push_back(model(mode, t00, t10, t01, t11, u00, u10, u01, u11,
                                     int'(fx), int'(fy), int'(flod)));
      tick;
      cycles++;
      if (xin) begin
        sent++;
        mode = 2'($urandom_range(0, 3));
        t00 = $urandom; t10 = $urandom; t01 = $urandom; t11 = $urandom;
        u00 = $urandom; u10 = $urandom; u01 = $urandom; u11 = $urandom;
        fx = 8'($urandom_range(0, 255)); fy = 8'($urandom_range(0, 255)); flod = 8'($urandom_range(0, 255));
      end
    end
    n_checks++;
    if (got !== 20) begin n_fail++; $display("FAIL stream_count got=%0d want=20 cycles=%0d", got, cycles); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_dup got=%b want=0", out_valid); end
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0;
    t00 = '0; t10 = '0; t01 = '0; t11 = '0;
    u00 = '0; u10 = '0; u01 = '0; u11 = '0;
    fx = '0; fy = '0; flod = '0;
    test_reset;
    test_bilinear_centre;
    test_weight_edges;
    test_nearest;
    test_trilinear;
    test_back_to_back;
    test_mid_reset;
    test_backpressure;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
